// File: rtl/vec_decrypt_pkg.sv
// Shared types and byte helpers for the vector-datapath decryption engine.
package vec_decrypt_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned DEFAULT_ROT = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] x,
                                              input int unsigned r);
    logic [2*BYTE_W-1:0] d;
    d = {x, x} << (r % BYTE_W);
    return d[2*BYTE_W-1:BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] rotr8(input logic [BYTE_W-1:0] x,
                                              input int unsigned r);
    logic [2*BYTE_W-1:0] d;
    d = {x, x} >> (r % BYTE_W);
    return d[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/byte_decrypt_unit.sv
// Combinational inverse of the byte transform c = rotl(p ^ prev, ROT) + k.
module byte_decrypt_unit
  import vec_decrypt_pkg::*;
#(
  parameter int unsigned ROT = DEFAULT_ROT
) (
  input  logic [BYTE_W-1:0] c,
  input  logic [BYTE_W-1:0] k,
  input  logic [BYTE_W-1:0] prev,
  output logic [BYTE_W-1:0] p
);

  logic [BYTE_W-1:0] diff;

  always_comb begin
    diff = c - k;
    p    = rotr8(diff, ROT) ^ prev;
  end

endmodule

// File: rtl/vec_byte_decryptor.sv
// Byte-serial decryption coprocessor: accepts a ciphertext word, undoes the
// chained per-byte transform MSB first, and returns plaintext on a handshake.
module vec_byte_decryptor
  import vec_decrypt_pkg::*;
#(
  parameter int unsigned ROT   = DEFAULT_ROT,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iv_load,
  input  logic [BYTE_W-1:0]            iv,
  input  logic [WORD_BYTES*BYTE_W-1:0] key,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_BYTES*BYTE_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_BYTES*BYTE_W-1:0] out_data,
  output logic [BYTE_W-1:0]            chain_out,
  output logic [CNT_W-1:0]             word_cnt
);

  localparam int unsigned WORD_W = WORD_BYTES * BYTE_W;
  localparam int unsigned IDX_W  = $clog2(WORD_BYTES);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [WORD_W-1:0]      cbuf;
  logic [WORD_W-1:0]      kbuf;
  logic [BYTE_W-1:0]      chain;
  logic [BYTE_W-1:0]      cur_c, cur_k, cur_p;
  logic                   accept, deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (idx == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        deliver   = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_c = cbuf[{idx, 3'b000} +: BYTE_W];
    cur_k = kbuf[{idx, 3'b000} +: BYTE_W];
  end

  byte_decrypt_unit #(.ROT(ROT)) u_byte (
    .c    (cur_c),
    .k    (cur_k),
    .prev (chain),
    .p    (cur_p)
  );

  // The ciphertext byte, not the recovered plaintext, feeds the next byte's chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= IDX_W'(WORD_BYTES - 1);
      cbuf     <= '0;
      kbuf     <= '0;
      out_data <= '0;
      chain    <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iv_load) begin
            chain    <= iv;
            word_cnt <= '0;
          end
          if (accept) begin
            cbuf <= in_data;
            kbuf <= key;
            idx  <= IDX_W'(WORD_BYTES - 1);
          end
        end
        BUSY: begin
          out_data[{idx, 3'b000} +: BYTE_W] <= cur_p;
          chain <= cur_c;
          idx   <= idx - 1'b1;
        end
        DONE: begin
          if (deliver) word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign chain_out = chain;

endmodule

// File: tb/tb_vec_byte_decryptor.sv
// Self-checking bench: plaintext is encrypted by a reference model and must
// come back out of the decryptor unchanged, with chain/count tracked alongside.
module tb_vec_byte_decryptor;

  localparam int unsigned ROT   = 3;
  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv_load = 1'b0;
  logic [7:0]  iv = '0;
  logic [31:0] key = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  chain_out;
  logic [CNT_W-1:0] word_cnt;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]       chain_m = '0;
  logic [CNT_W-1:0] cnt_m   = '0;

  always #5 clk = ~clk;

  vec_byte_decryptor #(.ROT(ROT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iv_load   (iv_load),
    .iv        (iv),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .chain_out (chain_out),
    .word_cnt  (word_cnt)
  );

  // Forward cipher: bytes 3..0, each c = rotl(p ^ prev, ROT) + k, prev := c.
  function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [31:0] k,
                                          input logic [7:0] prev_in,
                                          output logic [7:0] prev_out);
    logic [31:0] c;
    int unsigned x, prev;
    c = '0;
    prev = prev_in;
    for (int b = 3; b >= 0; b--) begin
      x = p[b*8 +: 8] ^ prev;
      x = ((x << ROT) | (x >> (8 - ROT))) & 255;
      x = (x + k[b*8 +: 8]) & 255;
      c[b*8 +: 8] = x[7:0];
      prev = x;
    end
    prev_out = prev[7:0];
    return c;
  endfunction

  task automatic do_word(input logic [31:0] c, input logic [31:0] k, input bit ld,
                         input logic [7:0] ivv, input bit busy_iv, input int unsigned hold,
                         output logic [31:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = c; key = k; iv_load = ld; iv = ivv;
    @(posedge clk); #1;
    in_valid = 1'b0; iv_load = busy_iv; iv = 8'h55;
    in_data = $urandom; key = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      iv_load = 1'b0;
      lat++;
    end
    res = out_data;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    vectors++; if (chain_out !== 8'h0) begin errors++; $display("FAIL reset_chain got=%h exp=0", chain_out); end
    vectors++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
    @(negedge clk); rst_n = 1'b1;
    chain_m = '0; cnt_m = '0;
  endtask

  task automatic test_known_vectors;
    logic [31:0] res; int lat;
    do_word(32'h081000FF, 32'h0, 1'b1, 8'h7C, 1'b0, 0, res, lat);
    vectors++; if (res !== 32'h7D0A10FF) begin errors++; $display("FAIL kv1_data got=%h exp=7d0a10ff", res); end
    vectors++; if (lat !== 4) begin errors++; $display("FAIL kv1_latency got=%0d exp=4", lat); end
    vectors++; if (chain_out !== 8'hFF) begin errors++; $display("FAIL kv1_chain got=%h exp=ff", chain_out); end
    vectors++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL kv1_cnt got=%0d exp=1", word_cnt); end
    do_word(32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1, res, lat);
    vectors++; if (res !== 32'hFF000000) begin errors++; $display("FAIL chain_data got=%h exp=ff000000", res); end
    vectors++; if (chain_out !== 8'h00) begin errors++; $display("FAIL chain_chain got=%h exp=00", chain_out); end
    vectors++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL chain_cnt got=%0d exp=2", word_cnt); end
    do_word(32'h01010101, 32'h01010101, 1'b1, 8'h00, 1'b0, 0, res, lat);
    vectors++; if (res !== 32'h00010101) begin errors++; $display("FAIL kv2_data got=%h exp=00010101", res); end
    vectors++; if (chain_out !== 8'h01) begin errors++; $display("FAIL kv2_chain got=%h exp=01", chain_out); end
    vectors++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL kv2_cnt got=%0d exp=1", word_cnt); end
    chain_m = 8'h01; cnt_m = 16'd1;
  endtask

  task automatic test_backpressure;
    logic [31:0] p, k, c; logic [7:0] nc; int lat;
    p = $urandom; k = $urandom;
    c = encrypt(p, k, chain_m, nc);
    @(negedge clk);
    in_valid = 1'b1; in_data = c; key = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    vectors++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    in_valid = 1'b1; in_data = $urandom; key = $urandom;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      vectors++; if (out_data !== p) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, out_data, p); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_not_accepted in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    in_valid = 1'b0;
    chain_m = nc; cnt_m = cnt_m + 1'b1;
    vectors++; if (chain_out !== chain_m) begin errors++; $display("FAIL bp_chain got=%h exp=%h", chain_out, chain_m); end
    vectors++; if (word_cnt !== cnt_m) begin errors++; $display("FAIL bp_cnt got=%0d exp=%0d", word_cnt, cnt_m); end
  endtask

  task automatic test_iv_same_cycle;
    logic [31:0] res; int lat;
    do_word(32'h081000FF, 32'h0, 1'b1, 8'h7C, 1'b1, 2, res, lat);
    vectors++; if (res !== 32'h7D0A10FF) begin errors++; $display("FAIL iv_same_data got=%h exp=7d0a10ff", res); end
    vectors++; if (chain_out !== 8'hFF) begin errors++; $display("FAIL iv_same_chain got=%h exp=ff", chain_out); end
    vectors++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL iv_same_cnt got=%0d exp=1", word_cnt); end
    chain_m = 8'hFF; cnt_m = 16'd1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] p, k, c, res; logic [7:0] nc, ivv; int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = $urandom; key = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    vectors++; if (chain_out !== 8'h00) begin errors++; $display("FAIL rmid_chain got=%h exp=00", chain_out); end
    vectors++; if (word_cnt !== '0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", word_cnt); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse cyc=%0d got=%b exp=0", i, out_valid); end
    end
    chain_m = '0; cnt_m = '0;
    ivv = $urandom; p = $urandom; k = $urandom;
    chain_m = ivv;
    c = encrypt(p, k, chain_m, nc);
    do_word(c, k, 1'b1, ivv, 1'b0, 0, res, lat);
    chain_m = nc; cnt_m = 16'd1;
    vectors++; if (res !== p) begin errors++; $display("FAIL rmid_after_data got=%h exp=%h", res, p); end
    vectors++; if (chain_out !== chain_m) begin errors++; $display("FAIL rmid_after_chain got=%h exp=%h", chain_out, chain_m); end
    vectors++; if (word_cnt !== cnt_m) begin errors++; $display("FAIL rmid_after_cnt got=%0d exp=%0d", word_cnt, cnt_m); end
  endtask

  task automatic test_random;
    logic [31:0] p, k, c, res; logic [7:0] nc, ivv; bit ld; int lat;
    for (int n = 0; n < 24; n++) begin
      ld = ($urandom % 4) == 0;
      ivv = $urandom; p = $urandom; k = $urandom;
      if (ld) begin chain_m = ivv; cnt_m = '0; end
      c = encrypt(p, k, chain_m, nc);
      do_word(c, k, ld, ivv, bit'($urandom % 2), $urandom % 3, res, lat);
      chain_m = nc; cnt_m = cnt_m + 1'b1;
      vectors++; if (res !== p) begin errors++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, res, p); end
      vectors++; if (lat !== 4) begin errors++; $display("FAIL rand_latency n=%0d got=%0d exp=4", n, lat); end
      vectors++; if (chain_out !== chain_m) begin errors++; $display("FAIL rand_chain n=%0d got=%h exp=%h", n, chain_out, chain_m); end
      vectors++; if (word_cnt !== cnt_m) begin errors++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, word_cnt, cnt_m); end
    end
  endtask

  initial begin
    test_reset;
    test_known_vectors;
    test_backpressure;
    test_iv_same_cycle;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
